// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - round-robin arbiter sharing a combinational imem between CPU fetch and debug reads
module imem_fetch_arbiter #(
    parameter int          AW        = 32,
    parameter int          MEM_BYTES = 64,
    parameter logic [31:0] ERR_WORD  = 32'hE1A0_0000,
    parameter bit          CPU_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req_valid,
    input  logic [AW-1:0] cpu_req_addr,
    output logic          cpu_req_ready,
    output logic          cpu_resp_valid,
    output logic [31:0]   cpu_resp_data,
    output logic          cpu_resp_err,
    input  logic          cpu_resp_ready,
    input  logic          dbg_req_valid,
    input  logic [AW-1:0] dbg_req_addr,
    output logic          dbg_req_ready,
    output logic          dbg_resp_valid,
    output logic [31:0]   dbg_resp_data,
    output logic          dbg_resp_err,
    input  logic          dbg_resp_ready,
    input  logic          dbg_halt,
    output logic [AW-1:0] mem_a,
    input  logic [31:0]   mem_rd
);

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_e;

    localparam logic [AW-1:0] MEM_LIMIT  = AW'(MEM_BYTES);
    localparam grant_e        LAST_RESET = CPU_FIRST ? GNT_DBG : GNT_CPU;

    grant_e      last_grant_q, last_grant_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic [31:0] cpu_data_q, cpu_data_d;
    logic        cpu_err_q, cpu_err_d;
    logic        dbg_valid_q, dbg_valid_d;
    logic [31:0] dbg_data_q, dbg_data_d;
    logic        dbg_err_q, dbg_err_d;

    logic        cpu_elig, dbg_elig;
    logic        grant_cpu, grant_dbg;
    logic        req_err;
    logic [31:0] req_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= LAST_RESET;
            cpu_valid_q  <= 1'b0;
            cpu_data_q   <= '0;
            cpu_err_q    <= 1'b0;
            dbg_valid_q  <= 1'b0;
            dbg_data_q   <= '0;
            dbg_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cpu_valid_q  <= cpu_valid_d;
            cpu_data_q   <= cpu_data_d;
            cpu_err_q    <= cpu_err_d;
            dbg_valid_q  <= dbg_valid_d;
            dbg_data_q   <= dbg_data_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    always_comb begin
        cpu_elig     = cpu_req_valid && !dbg_halt && (!cpu_valid_q || cpu_resp_ready);
        dbg_elig     = dbg_req_valid && (!dbg_valid_q || dbg_resp_ready);
        // On a tie the port that did not win last time takes this cycle.
        grant_cpu    = cpu_elig && (!dbg_elig || last_grant_q == GNT_DBG);
        grant_dbg    = dbg_elig && !grant_cpu;

        mem_a        = grant_dbg ? dbg_req_addr : cpu_req_addr;
        req_err      = (mem_a[1:0] != 2'b00) || (mem_a >= MEM_LIMIT);
        req_word     = req_err ? ERR_WORD : mem_rd;

        last_grant_d = last_grant_q;
        if (grant_cpu) begin
            last_grant_d = GNT_CPU;
        end else if (grant_dbg) begin
            last_grant_d = GNT_DBG;
        end

        cpu_valid_d = cpu_valid_q;
        cpu_data_d  = cpu_data_q;
        cpu_err_d   = cpu_err_q;
        if (grant_cpu) begin
            cpu_valid_d = 1'b1;
            cpu_data_d  = req_word;
            cpu_err_d   = req_err;
        end else if (cpu_resp_ready) begin
            cpu_valid_d = 1'b0;
        end

        dbg_valid_d = dbg_valid_q;
        dbg_data_d  = dbg_data_q;
        dbg_err_d   = dbg_err_q;
        if (grant_dbg) begin
            dbg_valid_d = 1'b1;
            dbg_data_d  = req_word;
            dbg_err_d   = req_err;
        end else if (dbg_resp_ready) begin
            dbg_valid_d = 1'b0;
        end
    end

    // Held reset masks the handshake so nothing looks accepted while state is cleared.
    assign cpu_req_ready  = grant_cpu && reset;
    assign dbg_req_ready  = grant_dbg && reset;
    assign cpu_resp_valid = cpu_valid_q;
    assign cpu_resp_data  = cpu_data_q;
    assign cpu_resp_err   = cpu_err_q;
    assign dbg_resp_valid = dbg_valid_q;
    assign dbg_resp_data  = dbg_data_q;
    assign dbg_resp_err   = dbg_err_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - self-checking bench for imem_fetch_arbiter
module tb_imem_fetch_arbiter;

    localparam logic [31:0] ERR_WORD = 32'hE1A0_0000;

    logic        clk, reset;
    logic        cpu_req_valid, cpu_req_ready, cpu_resp_valid, cpu_resp_err, cpu_resp_ready;
    logic [31:0] cpu_req_addr, cpu_resp_data;
    logic        dbg_req_valid, dbg_req_ready, dbg_resp_valid, dbg_resp_err, dbg_resp_ready;
    logic [31:0] dbg_req_addr, dbg_resp_data;
    logic        dbg_halt;
    logic [31:0] mem_a, mem_rd;
    logic [31:0] mem [16];

    int vectors = 0;
    int miscompares = 0;

    // Reference state: what each response port should be showing, and who won last.
    bit          m_cv, m_ce, m_dv, m_de;
    logic [31:0] m_cd, m_dd;
    int          m_last;
    bit          p_gc, p_gd;

    imem_fetch_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data), .cpu_resp_err(cpu_resp_err),
        .cpu_resp_ready(cpu_resp_ready),
        .dbg_req_valid(dbg_req_valid), .dbg_req_addr(dbg_req_addr), .dbg_req_ready(dbg_req_ready),
        .dbg_resp_valid(dbg_resp_valid), .dbg_resp_data(dbg_resp_data), .dbg_resp_err(dbg_resp_err),
        .dbg_resp_ready(dbg_resp_ready),
        .dbg_halt(dbg_halt), .mem_a(mem_a), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 64);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return is_err(a) ? ERR_WORD : mem[a / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, 63));
            1:       return 32'h40 + 32'(4 * $urandom_range(0, 3));
            2:       return 32'hFFFF_FFFC;
            default: return 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    function automatic void predict();
        bit ce, de;
        ce = reset && cpu_req_valid && !dbg_halt && (!m_cv || cpu_resp_ready);
        de = reset && dbg_req_valid && (!m_dv || dbg_resp_ready);
        if (ce && de) begin
            p_gc = (m_last == 1);
            p_gd = !p_gc;
        end else begin
            p_gc = ce;
            p_gd = de;
        end
    endfunction

    function automatic void model_reset();
        m_cv = 0; m_ce = 0; m_cd = '0;
        m_dv = 0; m_de = 0; m_dd = '0;
        m_last = 1;
    endfunction

    task automatic tick();
        predict();
        @(posedge clk);
        if (reset) begin
            if (p_gc) begin
                m_cv = 1; m_cd = word_at(cpu_req_addr); m_ce = is_err(cpu_req_addr);
            end else if (cpu_resp_ready) m_cv = 0;
            if (p_gd) begin
                m_dv = 1; m_dd = word_at(dbg_req_addr); m_de = is_err(dbg_req_addr);
            end else if (dbg_resp_ready) m_dv = 0;
            if (p_gc) m_last = 0;
            if (p_gd) m_last = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 0; model_reset();
        cpu_req_valid = 1; cpu_req_addr = 32'h0; cpu_resp_ready = 1;
        dbg_req_valid = 1; dbg_req_addr = 32'h4; dbg_resp_ready = 1; dbg_halt = 0;
        @(negedge clk);
        vectors++; if ({cpu_req_ready, dbg_req_ready} !== 2'b00) begin
            miscompares++; $display("FAIL reset_ready got=%b want=00", {cpu_req_ready, dbg_req_ready}); end
        vectors++; if ({cpu_resp_valid, dbg_resp_valid, cpu_resp_err, dbg_resp_err} !== 4'b0) begin
            miscompares++; $display("FAIL reset_resp got=%b want=0000",
                {cpu_resp_valid, dbg_resp_valid, cpu_resp_err, dbg_resp_err}); end
        vectors++; if (cpu_resp_data !== 32'h0 || dbg_resp_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_data got=%h/%h want=0", cpu_resp_data, dbg_resp_data); end
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        vectors++; if ({cpu_req_ready, dbg_req_ready} !== 2'b10) begin
            miscompares++; $display("FAIL reset_first_grant got=%b want=10", {cpu_req_ready, dbg_req_ready}); end
        tick();
        cpu_req_valid = 0; dbg_req_valid = 0;
        tick(); tick();
    endtask

    task automatic test_cpu_alone();
        cpu_resp_ready = 1; dbg_req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_req_valid = 1; cpu_req_addr = 32'(4 * i);
            @(negedge clk);
            vectors++; if (cpu_req_ready !== 1'b1 || mem_a !== 32'(4 * i)) begin
                miscompares++; $display("FAIL cpu_alone_accept[%0d] ready=%b mem_a=%h want 1/%h",
                    i, cpu_req_ready, mem_a, 4 * i); end
            tick();
            vectors++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== mem[i] || cpu_resp_err !== 1'b0) begin
                miscompares++; $display("FAIL cpu_alone_resp[%0d] got v=%b d=%h e=%b want 1/%h/0",
                    i, cpu_resp_valid, cpu_resp_data, cpu_resp_err, mem[i]); end
        end
        cpu_req_valid = 0;
        tick();
        vectors++; if (cpu_resp_valid !== 1'b0 || cpu_resp_data !== mem[2]) begin
            miscompares++; $display("FAIL cpu_alone_drain got v=%b d=%h want 0/%h",
                cpu_resp_valid, cpu_resp_data, mem[2]); end
    endtask

    task automatic test_back_to_back();
        bit prev_cpu;
        cpu_resp_ready = 1; dbg_resp_ready = 1;
        cpu_req_valid = 1; dbg_req_valid = 1;
        for (int i = 0; i < 8; i++) begin
            cpu_req_addr = 32'(4 * $urandom_range(0, 15));
            dbg_req_addr = 32'(4 * $urandom_range(0, 15));
            @(negedge clk);
            predict();
            vectors++; if (cpu_req_ready !== p_gc || dbg_req_ready !== p_gd) begin
                miscompares++; $display("FAIL contention_grant[%0d] got=%b%b want=%b%b",
                    i, cpu_req_ready, dbg_req_ready, p_gc, p_gd); end
            if (i > 0) begin
                vectors++; if (cpu_req_ready !== !prev_cpu) begin
                    miscompares++; $display("FAIL contention_alternate[%0d] cpu_ready=%b want %b",
                        i, cpu_req_ready, !prev_cpu); end
            end
            vectors++; if (mem_a !== (p_gd ? dbg_req_addr : cpu_req_addr)) begin
                miscompares++; $display("FAIL contention_mem_a[%0d] got=%h", i, mem_a); end
            prev_cpu = cpu_req_ready;
            tick();
            vectors++; if (cpu_resp_data !== m_cd || dbg_resp_data !== m_dd
                           || cpu_resp_valid !== m_cv || dbg_resp_valid !== m_dv) begin
                miscompares++; $display("FAIL contention_resp[%0d] got %b%h %b%h want %b%h %b%h", i,
                    cpu_resp_valid, cpu_resp_data, dbg_resp_valid, dbg_resp_data, m_cv, m_cd, m_dv, m_dd); end
        end
        cpu_req_valid = 0; dbg_req_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        cpu_resp_ready = 1; dbg_resp_ready = 1; dbg_req_valid = 0;
        cpu_req_valid = 1; cpu_req_addr = 32'h8;
        tick();
        cpu_resp_ready = 0; cpu_req_addr = 32'hC;
        dbg_req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            dbg_req_addr = 32'(16 + 4 * i);
            @(negedge clk);
            vectors++; if (cpu_req_ready !== 1'b0 || dbg_req_ready !== 1'b1) begin
                miscompares++; $display("FAIL bp_ready[%0d] got=%b%b want=01", i, cpu_req_ready, dbg_req_ready); end
            vectors++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== mem[2]) begin
                miscompares++; $display("FAIL bp_hold[%0d] got v=%b d=%h want 1/%h",
                    i, cpu_resp_valid, cpu_resp_data, mem[2]); end
            tick();
        end
        cpu_resp_ready = 1;
        @(negedge clk);
        vectors++; if (cpu_req_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release got=%b want=1", cpu_req_ready); end
        tick();
        vectors++; if (cpu_resp_data !== mem[3] || dbg_resp_data !== mem[6]) begin
            miscompares++; $display("FAIL bp_after got=%h/%h want=%h/%h",
                cpu_resp_data, dbg_resp_data, mem[3], mem[6]); end
        cpu_req_valid = 0; dbg_req_valid = 0;
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5];
        logic [31:0] want_d [5];
        bit          want_e [5];
        addrs  = '{32'h6, 32'h40, 32'h3C, 32'hFFFF_FFFC, 32'h1};
        want_e = '{1, 1, 0, 1, 1};
        want_d = '{ERR_WORD, ERR_WORD, mem[15], ERR_WORD, ERR_WORD};
        cpu_resp_ready = 1; dbg_req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_req_valid = 1; cpu_req_addr = addrs[i];
            tick();
            vectors++; if (cpu_resp_valid !== 1'b1 || cpu_resp_err !== want_e[i] || cpu_resp_data !== want_d[i]) begin
                miscompares++; $display("FAIL err_resp[%h] got v=%b e=%b d=%h want 1/%b/%h",
                    addrs[i], cpu_resp_valid, cpu_resp_err, cpu_resp_data, want_e[i], want_d[i]); end
        end
        cpu_req_valid = 1; cpu_req_addr = 32'h20;
        dbg_req_valid = 1; dbg_req_addr = 32'h42;
        tick();
        cpu_req_valid = 0;
        tick();
        vectors++; if (dbg_resp_err !== 1'b1 || dbg_resp_data !== ERR_WORD) begin
            miscompares++; $display("FAIL err_dbg got e=%b d=%h want 1/%h", dbg_resp_err, dbg_resp_data, ERR_WORD); end
        dbg_req_valid = 0;
        tick();
    endtask

    task automatic test_halt();
        cpu_resp_ready = 1; dbg_resp_ready = 1; dbg_req_valid = 0;
        cpu_req_valid = 1; cpu_req_addr = 32'h4;
        tick();
        cpu_resp_ready = 0; dbg_halt = 1; dbg_req_valid = 1; dbg_req_addr = 32'h8;
        @(negedge clk);
        vectors++; if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== mem[1]) begin
            miscompares++; $display("FAIL halt_pending got v=%b d=%h want 1/%h", cpu_resp_valid, cpu_resp_data, mem[1]); end
        cpu_resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if (cpu_req_ready !== 1'b0 || dbg_req_ready !== 1'b1) begin
                miscompares++; $display("FAIL halt_grant[%0d] got=%b%b want=01", i, cpu_req_ready, dbg_req_ready); end
            tick();
            vectors++; if (cpu_resp_valid !== 1'b0) begin
                miscompares++; $display("FAIL halt_cpu_drain[%0d] got=%b want=0", i, cpu_resp_valid); end
        end
        dbg_halt = 0;
        @(negedge clk);
        vectors++; if (cpu_req_ready !== 1'b1) begin
            miscompares++; $display("FAIL halt_release got=%b want=1", cpu_req_ready); end
        tick();
        #2;
        reset = 0;
        #1;
        vectors++; if (cpu_resp_valid !== 1'b0 || dbg_resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_midresp got=%b%b want=00", cpu_resp_valid, dbg_resp_valid); end
        model_reset();
        cpu_req_valid = 0; dbg_req_valid = 0;
        @(posedge clk); #1;
        reset = 1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cpu_req_valid  = ($urandom_range(0, 3) != 0);
            dbg_req_valid  = ($urandom_range(0, 2) != 0);
            cpu_req_addr   = rand_addr();
            dbg_req_addr   = rand_addr();
            cpu_resp_ready = ($urandom_range(0, 3) != 0);
            dbg_resp_ready = ($urandom_range(0, 2) != 0);
            dbg_halt       = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            predict();
            vectors++; if (cpu_req_ready !== p_gc || dbg_req_ready !== p_gd) begin
                miscompares++; $display("FAIL rand_grant[%0d] got=%b%b want=%b%b",
                    i, cpu_req_ready, dbg_req_ready, p_gc, p_gd); end
            vectors++; if (mem_a !== (p_gd ? dbg_req_addr : cpu_req_addr)) begin
                miscompares++; $display("FAIL rand_mem_a[%0d] got=%h", i, mem_a); end
            vectors++; if ({cpu_resp_valid, cpu_resp_err, cpu_resp_data} !== {m_cv, m_ce, m_cd}) begin
                miscompares++; $display("FAIL rand_cpu_resp[%0d] got=%b%b%h want=%b%b%h",
                    i, cpu_resp_valid, cpu_resp_err, cpu_resp_data, m_cv, m_ce, m_cd); end
            vectors++; if ({dbg_resp_valid, dbg_resp_err, dbg_resp_data} !== {m_dv, m_de, m_dd}) begin
                miscompares++; $display("FAIL rand_dbg_resp[%0d] got=%b%b%h want=%b%b%h",
                    i, dbg_resp_valid, dbg_resp_err, dbg_resp_data, m_dv, m_de, m_dd); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom();
        test_reset();
        test_cpu_alone();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
